// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Holds the EX/MEM pipeline register and a word-organised data memory.
// It performs the store or load of the instruction in MEM.
// Ports:
//   clk, reset              - clock and async active-high reset (clears regs and memory)
//   PC, IR, ALUout, RtData,
//   WA                      - instruction state leaving EX
//   mem_PC, mem_IR,
//   mem_ALUout, mem_WA      - latched state; mem_ALUout/mem_WA also feed forwarding
//   dout                    - extended load data, combinational from the latched address
module mem_stage #(
  parameter int unsigned DM_WORDS = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] IR,
  input  logic [31:0] ALUout,
  input  logic [31:0] RtData,
  input  logic [4:0]  WA,
  output logic [31:0] mem_PC,
  output logic [31:0] mem_IR,
  output logic [31:0] mem_ALUout,
  output logic [4:0]  mem_WA,
  output logic [31:0] dout
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  logic [31:0]   rt_q;
  logic [AW-1:0] idx;
  logic [31:0]   words [DM_WORDS];
  logic [31:0]   w;
  logic [31:0]   merged;
  logic          we;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // EX/MEM pipeline register; never stalls or flushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_PC     <= RESET_PC;
      mem_IR     <= '0;
      mem_ALUout <= '0;
      mem_WA     <= '0;
      rt_q       <= '0;
    end else begin
      mem_PC     <= PC;
      mem_IR     <= IR;
      mem_ALUout <= ALUout;
      mem_WA     <= WA;
      rt_q       <= RtData;
`ifndef SYNTHESIS
      if (we)
        $display("%d@%h: *%h <= %h", $time, mem_PC, {mem_ALUout[31:2], 2'b00}, merged);
`endif
    end
  end

  // Upper address bits are dropped, so addresses wrap modulo the memory size
  assign idx = mem_ALUout[AW+1:2];
  assign w   = words[idx];

  // Store merge and load extension
  always_comb begin
    we       = 1'b0;
    merged   = w;
    dout     = w;
    sel_byte = w[{mem_ALUout[1:0], 3'b000} +: 8];
    sel_half = mem_ALUout[1] ? w[31:16] : w[15:0];
    unique case (mem_IR[31:26])
      OP_SW: begin
        we     = 1'b1;
        merged = rt_q;
      end
      OP_SH: begin
        we = 1'b1;
        if (mem_ALUout[1]) merged[31:16] = rt_q[15:0];
        else               merged[15:0]  = rt_q[15:0];
      end
      OP_SB: begin
        we = 1'b1;
        merged[{mem_ALUout[1:0], 3'b000} +: 8] = rt_q[7:0];
      end
      OP_LW:  dout = w;
      OP_LB:  dout = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: dout = {24'h0, sel_byte};
      OP_LH:  dout = {{16{sel_half[15]}}, sel_half};
      OP_LHU: dout = {16'h0, sel_half};
      default: dout = w;
    endcase
  end

  // One register per word so reset can clear the whole memory asynchronously
  for (genvar g = 0; g < DM_WORDS; g++) begin : g_word
    logic [31:0] word_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                         word_q <= '0;
      else if (we && (idx == AW'(g)))    word_q <= merged;
    end
    assign words[g] = word_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, IR, ALUout, RtData;
  logic [4:0]  WA;
  logic [31:0] mem_PC, mem_IR, mem_ALUout, dout;
  logic [4:0]  mem_WA;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_LB   = 32'h8000_0000;
  localparam logic [31:0] I_LBU  = 32'h9000_0000;
  localparam logic [31:0] I_LH   = 32'h8400_0000;
  localparam logic [31:0] I_LHU  = 32'h9400_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_SB   = 32'hA000_0000;
  localparam logic [31:0] I_SH   = 32'hA400_0000;
  localparam logic [31:0] I_ADDU = 32'h0109_4021;

  mem_stage dut (
    .clk(clk), .reset(reset), .PC(PC), .IR(IR), .ALUout(ALUout),
    .RtData(RtData), .WA(WA), .mem_PC(mem_PC), .mem_IR(mem_IR),
    .mem_ALUout(mem_ALUout), .mem_WA(mem_WA), .dout(dout)
  );

  always #5 clk = ~clk;

  // Present one instruction to the stage; returns 1 time unit after it enters MEM
  task automatic issue(input logic [31:0] pc, input logic [31:0] ir,
                       input logic [31:0] alu, input logic [31:0] rt,
                       input logic [4:0] wa);
    PC = pc; IR = ir; ALUout = alu; RtData = rt; WA = wa;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    issue(32'h0000_4000, I_ADDU, 32'h0000_0055, 32'h0, 5'd3);
    checks++;
    if (mem_PC !== 32'h0000_4000) begin
      failures++; $display("FAIL pre_reset_pc got=%h exp=%h", mem_PC, 32'h0000_4000);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (mem_PC !== 32'h0000_3000) begin
      failures++; $display("FAIL reset_pc got=%h exp=%h", mem_PC, 32'h0000_3000);
    end
    checks++;
    if (mem_IR !== 32'h0 || mem_ALUout !== 32'h0) begin
      failures++; $display("FAIL reset_ir_alu got=%h/%h exp=0/0", mem_IR, mem_ALUout);
    end
    checks++;
    if (mem_WA !== 5'd0) begin
      failures++; $display("FAIL reset_wa got=%h exp=0", mem_WA);
    end
    checks++;
    if (dout !== 32'h0) begin
      failures++; $display("FAIL reset_dout got=%h exp=0", dout);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_word;
    issue(32'h0000_3000, I_SW, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    issue(32'h0000_3004, I_LW, 32'h0000_0010, 32'h0, 5'd9);
    checks++;
    if (dout !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL word_lw got=%h exp=%h", dout, 32'hDEAD_BEEF);
    end
    checks++;
    if (mem_WA !== 5'd9 || mem_PC !== 32'h0000_3004) begin
      failures++; $display("FAIL word_regs got=%h/%h exp=09/00003004", mem_WA, mem_PC);
    end
  endtask

  // Table of loads checked after the stores that set up the bytes/halfwords
  task automatic test_subword;
    logic [31:0] ir  [10];
    logic [31:0] adr [10];
    logic [31:0] exp [10];
    issue(32'h0000_3010, I_SW, 32'h0000_0020, 32'h1122_3344, 5'd0);
    issue(32'h0000_3014, I_SB, 32'h0000_0021, 32'h0000_00AA, 5'd0);
    issue(32'h0000_3018, I_SH, 32'h0000_0032, 32'h0000_8001, 5'd0);
    issue(32'h0000_301C, I_SB, 32'h0000_0023, 32'hFFFF_FF55, 5'd0);
    issue(32'h0000_3020, I_SH, 32'h0000_0030, 32'hABCD_1234, 5'd0);
    ir[0] = I_LB;  adr[0] = 32'h21; exp[0] = 32'hFFFF_FFAA;
    ir[1] = I_LBU; adr[1] = 32'h21; exp[1] = 32'h0000_00AA;
    ir[2] = I_LW;  adr[2] = 32'h20; exp[2] = 32'h5522_AA44;
    ir[3] = I_LB;  adr[3] = 32'h20; exp[3] = 32'h0000_0044;
    ir[4] = I_LH;  adr[4] = 32'h32; exp[4] = 32'hFFFF_8001;
    ir[5] = I_LHU; adr[5] = 32'h32; exp[5] = 32'h0000_8001;
    ir[6] = I_LH;  adr[6] = 32'h33; exp[6] = 32'hFFFF_8001;
    ir[7] = I_LHU; adr[7] = 32'h33; exp[7] = 32'h0000_8001;
    ir[8] = I_LW;  adr[8] = 32'h30; exp[8] = 32'h8001_1234;
    ir[9] = I_LW;  adr[9] = 32'h33; exp[9] = 32'h8001_1234;
    for (int i = 0; i < 10; i++) begin
      issue(32'h0000_3100, ir[i], adr[i], 32'h0, 5'd1);
      checks++;
      if (dout !== exp[i]) begin
        failures++;
        $display("FAIL subword_load[%0d] ir=%h addr=%h got=%h exp=%h", i, ir[i], adr[i], dout, exp[i]);
      end
    end
  endtask

  task automatic test_wrap_passthrough;
    issue(32'h0000_3200, I_SW, 32'h0000_1004, 32'hCAFE_F00D, 5'd0);
    issue(32'h0000_3204, I_LW, 32'h0000_0004, 32'h0, 5'd2);
    checks++;
    if (dout !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL wrap_lw got=%h exp=%h", dout, 32'hCAFE_F00D);
    end
    issue(32'h0000_3208, I_ADDU, 32'h0000_1234, 32'hFFFF_FFFF, 5'd8);
    checks++;
    if (mem_ALUout !== 32'h0000_1234 || mem_WA !== 5'd8) begin
      failures++; $display("FAIL addu_fwd got=%h/%h exp=00001234/08", mem_ALUout, mem_WA);
    end
    checks++;
    if (mem_IR !== I_ADDU) begin
      failures++; $display("FAIL addu_ir got=%h exp=%h", mem_IR, I_ADDU);
    end
    issue(32'h0000_320C, I_LW, 32'h0000_0234, 32'h0, 5'd2);
    checks++;
    if (dout !== 32'h0) begin
      failures++; $display("FAIL addu_nowrite got=%h exp=0", dout);
    end
  endtask

  task automatic test_back_to_back;
    issue(32'h0000_3300, I_SB, 32'h0000_0040, 32'h0000_0011, 5'd0);
    issue(32'h0000_3304, I_SB, 32'h0000_0041, 32'h0000_0022, 5'd0);
    issue(32'h0000_3308, I_SH, 32'h0000_0042, 32'h0000_3344, 5'd0);
    issue(32'h0000_330C, I_LW, 32'h0000_0040, 32'h0, 5'd4);
    checks++;
    if (dout !== 32'h3344_2211) begin
      failures++; $display("FAIL b2b_merge got=%h exp=%h", dout, 32'h3344_2211);
    end
  endtask

  task automatic test_reset_mid_store;
    issue(32'h0000_3400, I_SW, 32'h0000_0050, 32'h1234_5678, 5'd0);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    issue(32'h0000_3404, I_LW, 32'h0000_0050, 32'h0, 5'd5);
    checks++;
    if (dout !== 32'h0) begin
      failures++; $display("FAIL reset_cancel_store got=%h exp=0", dout);
    end
    issue(32'h0000_3408, I_LW, 32'h0000_0010, 32'h0, 5'd5);
    checks++;
    if (dout !== 32'h0) begin
      failures++; $display("FAIL reset_clears_mem got=%h exp=0", dout);
    end
  endtask

  initial begin
    reset = 1'b1;
    PC = '0; IR = '0; ALUout = '0; RtData = '0; WA = '0;
    #12 reset = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_wrap_passthrough();
    test_back_to_back();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
